serial_deserializer: RTL and testbench

- Downstream consumer of a 1-bit serial data stream, e.g. the single-bit output of a select/mux stage.
- Collects WIDTH consecutive accepted bits into a parallel word.
- Buffers completed words in a 2-entry output queue and presents them on a valid/ready interface.
- Provides backpressure to the serial source and a flush to discard a partial word.

---
 rtl/serial_deserializer_if.sv | 26 ++
 rtl/serial_deserializer.sv | 91 +++++++++
 tb/tb_serial_deserializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_deserializer_if.sv
// Serial-in / parallel-out handshake bundle for serial_deserializer.
// slave is the deserializer side; master is the serial source plus word consumer.
interface serial_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             data_i;
  logic             valid_i;
  logic             ready_o;
  logic             flush_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic [CW-1:0]    bit_count_o;

  modport slave (
    input  data_i, valid_i, flush_i, ready_i,
    output ready_o, data_o, valid_o, bit_count_o
  );

  modport master (
    output data_i, valid_i, flush_i, ready_i,
    input  ready_o, data_o, valid_o, bit_count_o
  );
endinterface

// File: rtl/serial_deserializer.sv
// Collects WIDTH accepted serial bits into a word and queues completed words
// in a 2-entry FIFO presented on a valid/ready interface.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  serial_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] mem_reg [2];
  logic             head_reg;
  logic [1:0]       occ_reg, occ_next;

  logic [WIDTH-1:0] place_mask;
  logic [WIDTH-1:0] word_next;
  logic             ready;
  logic             accept;
  logic             last_bit;
  logic             push;
  logic             pop;
  logic             tail;

  // One-hot position of the incoming bit, selected by the current count.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_place
      if (MSB_FIRST) begin : g_msb
        assign place_mask[gi] = (count_reg == CW'(WIDTH - 1 - gi));
      end else begin : g_lsb
        assign place_mask[gi] = (count_reg == CW'(gi));
      end
    end
  endgenerate

  assign ready     = (occ_reg != 2'd2);
  assign accept    = bus.valid_i && ready;
  assign last_bit  = (count_reg == CW'(WIDTH - 1));
  assign word_next = shift_reg | (bus.data_i ? place_mask : '0);
  assign push      = accept && last_bit && !bus.flush_i;
  assign pop       = (occ_reg != 2'd0) && bus.ready_i;
  // Free slot is the head when empty, the other entry when one word is held.
  assign tail      = head_reg ^ occ_reg[0];

  always_comb begin
    shift_next = shift_reg;
    count_next = count_reg;
    if (bus.flush_i) begin
      shift_next = '0;
      count_next = '0;
    end else if (accept) begin
      if (last_bit) begin
        shift_next = '0;
        count_next = '0;
      end else begin
        shift_next = word_next;
        count_next = count_reg + CW'(1);
      end
    end
    occ_next = occ_reg + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_reg <= '0;
      count_reg <= '0;
      occ_reg   <= 2'd0;
      head_reg  <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      count_reg <= count_next;
      occ_reg   <= occ_next;
      head_reg  <= head_reg ^ pop;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_reg[tail] <= word_next;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.valid_o     = (occ_reg != 2'd0);
  assign bus.data_o      = (occ_reg != 2'd0) ? mem_reg[head_reg] : '0;
  assign bus.bit_count_o = count_reg;
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: an MSB-first and an LSB-first
// instance receive identical stimulus.
module tb_serial_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data = 1'b0;
  logic valid = 1'b0;
  logic flush = 1'b0;
  logic rdy = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_deserializer_if #(.WIDTH(8)) ifm ();
  serial_deserializer_if #(.WIDTH(8)) ifl ();

  assign ifm.data_i  = data;
  assign ifm.valid_i = valid;
  assign ifm.flush_i = flush;
  assign ifm.ready_i = rdy;
  assign ifl.data_i  = data;
  assign ifl.valid_i = valid;
  assign ifl.flush_i = flush;
  assign ifl.ready_i = rdy;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk_i(clk), .rst_i(rst), .bus(ifm.slave));
  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk_i(clk), .rst_i(rst), .bus(ifl.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one bit and hold it until the MSB-first instance accepts it.
  task automatic send_bit(input logic b);
    int n;
    data  = b;
    valid = 1'b1;
    n = 0;
    while (ifm.ready_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_bit_timeout ready_o=%b required=1", ifm.ready_o);
    end
    step();
    valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 4;
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifm.valid_o); end
    if (ifm.data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", ifm.data_o); end
    if (ifm.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ifm.ready_o); end
    if (ifm.bit_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ifm.bit_count_o); end
    $display("reset: valid=%b data=%h ready=%b count=%0d", ifm.valid_o, ifm.data_o, ifm.ready_o, ifm.bit_count_o);
  endtask

  task automatic test_bit_order();
    logic [7:0] pat;
    pat = 8'hB2;
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data  = pat[7-i];
      valid = 1'b1;
      step();
      checks++;
      if (i < 7 && ifl.bit_count_o !== 3'(i + 1)) begin
        errors++;
        $display("FAIL bit_count_step got=%0d exp=%0d", ifl.bit_count_o, i + 1);
      end
    end
    valid = 1'b0;
    checks += 4;
    if (ifm.valid_o !== 1'b1) begin errors++; $display("FAIL msb_valid got=%b exp=1", ifm.valid_o); end
    if (ifm.data_o !== 8'hB2) begin errors++; $display("FAIL msb_data got=%h exp=b2", ifm.data_o); end
    if (ifl.data_o !== 8'h4D) begin errors++; $display("FAIL lsb_data got=%h exp=4d", ifl.data_o); end
    if (ifl.bit_count_o !== 3'd0) begin errors++; $display("FAIL count_wrap got=%0d exp=0", ifl.bit_count_o); end
    $display("bit_order: msb=%h lsb=%h", ifm.data_o, ifl.data_o);
    step();
    checks++;
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL queue_drained got=%b exp=0", ifm.valid_o); end
  endtask

  task automatic test_backpressure();
    rdy = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    checks += 2;
    if (ifm.ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", ifm.ready_o); end
    if (ifm.data_o !== 8'hA5) begin errors++; $display("FAIL bp_head got=%h exp=a5", ifm.data_o); end
    data  = 1'b1;
    valid = 1'b1;
    step();
    step();
    checks += 2;
    if (ifm.bit_count_o !== 3'd0) begin errors++; $display("FAIL bp_held_count got=%0d exp=0", ifm.bit_count_o); end
    if (ifm.ready_o !== 1'b0) begin errors++; $display("FAIL bp_held_ready got=%b exp=0", ifm.ready_o); end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    checks += 3;
    if (ifm.ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", ifm.ready_o); end
    if (ifm.data_o !== 8'h3C) begin errors++; $display("FAIL bp_second got=%h exp=3c", ifm.data_o); end
    if (ifm.bit_count_o !== 3'd0) begin errors++; $display("FAIL bp_no_accept got=%0d exp=0", ifm.bit_count_o); end
    send_word(8'hFF);
    rdy = 1'b1;
    step();
    checks += 2;
    if (ifm.valid_o !== 1'b1) begin errors++; $display("FAIL bp_third_valid got=%b exp=1", ifm.valid_o); end
    if (ifm.data_o !== 8'hFF) begin errors++; $display("FAIL bp_third got=%h exp=ff", ifm.data_o); end
    step();
    checks++;
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", ifm.valid_o); end
    $display("backpressure: a5,3c,ff sequence done");
  endtask

  task automatic test_flush();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    checks++;
    if (ifm.bit_count_o !== 3'd5) begin errors++; $display("FAIL flush_pre_count got=%0d exp=5", ifm.bit_count_o); end
    data  = 1'b1;
    valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b0;
    checks += 2;
    if (ifm.bit_count_o !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", ifm.bit_count_o); end
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_push got=%b exp=0", ifm.valid_o); end
    send_word(8'h81);
    checks += 2;
    if (ifm.valid_o !== 1'b1) begin errors++; $display("FAIL flush_word_valid got=%b exp=1", ifm.valid_o); end
    if (ifm.data_o !== 8'h81) begin errors++; $display("FAIL flush_word got=%h exp=81", ifm.data_o); end
    rdy = 1'b1;
    step();
    checks++;
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL flush_single_word got=%b exp=0", ifm.valid_o); end
    $display("flush: partial dropped, word=81");
  endtask

  task automatic test_push_pop();
    logic [7:0] w;
    w = 8'h22;
    rdy = 1'b0;
    send_word(8'h11);
    checks++;
    if (ifm.data_o !== 8'h11) begin errors++; $display("FAIL pp_head got=%h exp=11", ifm.data_o); end
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    rdy = 1'b1;
    send_bit(w[0]);
    checks += 3;
    if (ifm.valid_o !== 1'b1) begin errors++; $display("FAIL pp_valid got=%b exp=1", ifm.valid_o); end
    if (ifm.data_o !== 8'h22) begin errors++; $display("FAIL pp_data got=%h exp=22", ifm.data_o); end
    if (ifm.ready_o !== 1'b1) begin errors++; $display("FAIL pp_ready got=%b exp=1", ifm.ready_o); end
    step();
    checks++;
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL pp_occ_one got=%b exp=0", ifm.valid_o); end
    $display("push_pop: head after=22");
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 2;
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL rst_full_valid got=%b exp=0", ifm.valid_o); end
    if (ifm.ready_o !== 1'b1) begin errors++; $display("FAIL rst_full_ready got=%b exp=1", ifm.ready_o); end
    send_word(8'h77);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 4;
    if (ifm.valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", ifm.valid_o); end
    if (ifm.data_o !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h exp=00", ifm.data_o); end
    if (ifm.ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ifm.ready_o); end
    if (ifm.bit_count_o !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", ifm.bit_count_o); end
    send_word(8'h5A);
    checks += 2;
    if (ifm.valid_o !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid got=%b exp=1", ifm.valid_o); end
    if (ifm.data_o !== 8'h5A) begin errors++; $display("FAIL rst_fresh_data got=%h exp=5a", ifm.data_o); end
    $display("reset_mid: fresh word=%h", ifm.data_o);
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
